// File: rtl/i_cache_refill_pkg.sv
// Shared types and constants for the instruction-cache line refill engine.
package i_cache_refill_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } refill_state_e;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // Number of byte-offset bits inside one cache line.
   function automatic int line_offset_width(input int number_word, input int width_data);
      return $clog2((number_word * width_data) / 8);
   endfunction

endpackage

// File: rtl/i_cache_line_buffer.sv
// Line assembly buffer: beat counter plus per-slot word capture.
module i_cache_line_buffer #(
   parameter int WIDTH_DATA  = 32,
   parameter int NUMBER_WORD = 8,
   localparam int CNT_W      = $clog2(NUMBER_WORD)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              clear,
   input  logic                              wr_en,
   input  logic [WIDTH_DATA-1:0]             wr_data,
   output logic [CNT_W-1:0]                  beat_cnt,
   output logic [WIDTH_DATA*NUMBER_WORD-1:0] line_data
);

   logic [CNT_W-1:0]                  beat_cnt_r;
   logic [WIDTH_DATA*NUMBER_WORD-1:0] line_data_r;

   // Beat counter: zeroed when a refill starts, wraps naturally after the last slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt_r <= {CNT_W{1'b0}};
      end else if (clear) begin
         beat_cnt_r <= {CNT_W{1'b0}};
      end else if (wr_en) begin
         beat_cnt_r <= beat_cnt_r + CNT_W'(1);
      end else begin
         beat_cnt_r <= beat_cnt_r;
      end
   end

   // Word slots: only the slot addressed by the counter is written; untouched slots keep the old line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_data_r <= {(WIDTH_DATA*NUMBER_WORD){1'b0}};
      end else begin
         for (int i = 0; i < NUMBER_WORD; i++) begin
            if (wr_en && (beat_cnt_r == CNT_W'(i))) begin
               line_data_r[i*WIDTH_DATA +: WIDTH_DATA] <= wr_data;
            end
         end
      end
   end

   assign beat_cnt  = beat_cnt_r;
   assign line_data = line_data_r;

endmodule

// File: rtl/i_cache_refill.sv
// Instruction-cache line refill: issues one AXI4 INCR burst per miss and assembles the line.
module i_cache_refill #(
   parameter int WIDTH_DATA  = 32,
   parameter int NUMBER_WORD = 8,
   parameter int WIDTH_ADD   = 32
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              miss_req,
   input  logic [WIDTH_ADD-1:0]              miss_add,
   output logic                              refill_busy,
   output logic [WIDTH_DATA*NUMBER_WORD-1:0] line_data,
   output logic                              line_valid,
   output logic                              line_error,
   output logic [WIDTH_ADD-1:0]              axi_araddr,
   output logic [7:0]                        axi_arlen,
   output logic [2:0]                        axi_arsize,
   output logic [1:0]                        axi_arburst,
   output logic                              axi_arvalid,
   input  logic                              axi_arready,
   input  logic [WIDTH_DATA-1:0]             axi_rdata,
   input  logic [1:0]                        axi_rresp,
   input  logic                              axi_rlast,
   input  logic                              axi_rvalid,
   output logic                              axi_rready
);
   import i_cache_refill_pkg::*;

   localparam int                   OFF_W     = line_offset_width(NUMBER_WORD, WIDTH_DATA);
   localparam int                   CNT_W     = $clog2(NUMBER_WORD);
   localparam logic [WIDTH_ADD-1:0] LINE_MASK = {WIDTH_ADD{1'b1}} << OFF_W;
   localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(NUMBER_WORD - 1);
   localparam logic [7:0]           AR_LEN    = 8'(NUMBER_WORD - 1);
   localparam logic [2:0]           AR_SIZE   = 3'($clog2(WIDTH_DATA / 8));

   refill_state_e        state_r, state_nxt_s;
   logic [WIDTH_ADD-1:0] addr_r;
   logic                 err_r, err_nxt_s;
   logic                 miss_accept_s, beat_fire_s, beat_bad_s;
   logic                 busy_r, arvalid_r, rready_r, line_valid_r, line_error_r;
   logic [CNT_W-1:0]     beat_cnt_s;

   assign beat_fire_s = rready_r & axi_rvalid;
   assign beat_bad_s  = (axi_rresp == AXI_RESP_SLVERR) | (axi_rresp == AXI_RESP_DECERR);

   // Next-state and sticky-error computation.
   always_comb begin
      state_nxt_s   = state_r;
      err_nxt_s     = err_r;
      miss_accept_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (miss_req) begin
               state_nxt_s   = ST_ADDR;
               err_nxt_s     = 1'b0;
               miss_accept_s = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (arvalid_r && axi_arready) begin
               state_nxt_s = ST_DATA;
            end else begin
               state_nxt_s = ST_ADDR;
            end
         end
         ST_DATA: begin
            if (beat_fire_s) begin
               if (beat_cnt_s == LAST_BEAT) begin
                  // Final slot filled: a missing RLAST here is a burst-length violation.
                  state_nxt_s = ST_DONE;
                  err_nxt_s   = err_r | beat_bad_s | ~axi_rlast;
               end else if (axi_rlast) begin
                  // Burst ended short: keep the stale tail and flag the line.
                  state_nxt_s = ST_DONE;
                  err_nxt_s   = 1'b1;
               end else begin
                  state_nxt_s = ST_DATA;
                  err_nxt_s   = err_r | beat_bad_s;
               end
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State, error flag and line-aligned miss address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         err_r   <= 1'b0;
         addr_r  <= {WIDTH_ADD{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         err_r   <= err_nxt_s;
         if (miss_accept_s) begin
            addr_r <= miss_add & LINE_MASK;
         end else begin
            addr_r <= addr_r;
         end
      end
   end

   // Control outputs registered from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r       <= 1'b0;
         arvalid_r    <= 1'b0;
         rready_r     <= 1'b0;
         line_valid_r <= 1'b0;
         line_error_r <= 1'b0;
      end else begin
         busy_r       <= (state_nxt_s != ST_IDLE);
         arvalid_r    <= (state_nxt_s == ST_ADDR);
         rready_r     <= (state_nxt_s == ST_DATA);
         line_valid_r <= (state_nxt_s == ST_DONE);
         line_error_r <= (state_nxt_s == ST_DONE) & err_nxt_s;
      end
   end

   i_cache_line_buffer #(
      .WIDTH_DATA  (WIDTH_DATA),
      .NUMBER_WORD (NUMBER_WORD)
   ) u_line_buffer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (miss_accept_s),
      .wr_en     (beat_fire_s),
      .wr_data   (axi_rdata),
      .beat_cnt  (beat_cnt_s),
      .line_data (line_data)
   );

   assign refill_busy = busy_r;
   assign line_valid  = line_valid_r;
   assign line_error  = line_error_r;
   assign axi_araddr  = addr_r;
   assign axi_arlen   = AR_LEN;
   assign axi_arsize  = AR_SIZE;
   assign axi_arburst = AXI_BURST_INCR;
   assign axi_arvalid = arvalid_r;
   assign axi_rready  = rready_r;

endmodule

// File: doc/i_cache_refill.md
I_CACHE_REFILL -- requirements
Module: I_Cache_Refill

Interface
REQ-001 The block SHALL have parameter WIDTH_DATA, default 32: instruction word / AXI data width.
REQ-002 The block SHALL have parameter NUMBER_WORD, default 8: words per cache line and beats per burst.
REQ-003 The block SHALL have parameter WIDTH_ADD, default 32: address width.
REQ-004 The block SHALL have port CLK  in  1: single clock; all logic is rising-edge.
REQ-005 The block SHALL have port RST  in  1: reset, asynchronous, active-low.
REQ-006 The block SHALL have port Miss_Req  in  1: cache miss, refill requested.
REQ-007 The block SHALL have port Miss_ADD  in  WIDTH_ADD: missing instruction address.
REQ-008 The block SHALL have port Refill_Busy  out  1: refill in progress.
REQ-009 The block SHALL have port Line_Data  out  WIDTH_DATA*NUMBER_WORD: assembled line, word 0 in bits [WIDTH_DATA-1:0].
REQ-010 The block SHALL have port Line_Valid  out  1: one-cycle pulse, line complete.
REQ-011 The block SHALL have port Line_Error  out  1: qualified by Line_Valid; bad response or burst-length violation.
REQ-012 The block SHALL have ports AXI_ARADDR out WIDTH_ADD, AXI_ARLEN out 8, AXI_ARSIZE out 3, AXI_ARBURST out 2, AXI_ARVALID out 1, AXI_ARREADY in 1: AXI4 read-address channel.
REQ-013 The block SHALL have ports AXI_RDATA in WIDTH_DATA, AXI_RRESP in 2, AXI_RLAST in 1, AXI_RVALID in 1, AXI_RREADY out 1: AXI4 read-data channel.

Function
REQ-014 The FSM SHALL have states IDLE, ADDR, DATA, DONE; Refill_Busy SHALL be 1 in every state except IDLE.
REQ-015 In IDLE with Miss_Req=1 at an edge, the block SHALL latch Miss_ADD with its low log2(NUMBER_WORD*WIDTH_DATA/8) bits cleared (line-aligned), clear the beat counter and the error flag, and enter ADDR.
REQ-016 In ADDR, AXI_ARVALID SHALL be 1 with AXI_ARADDR equal to the latched address, AXI_ARLEN=NUMBER_WORD-1, AXI_ARSIZE=log2(WIDTH_DATA/8) (3'b010 at default), and AXI_ARBURST=2'b01 (INCR); all AR outputs SHALL be stable until AXI_ARREADY=1.
REQ-017 When AXI_ARVALID and AXI_ARREADY are both 1, the FSM SHALL enter DATA; AXI_ARVALID SHALL be 0 in every state except ADDR.
REQ-018 In DATA, AXI_RREADY SHALL be 1; AXI_RREADY SHALL be 0 in every other state.
REQ-019 Each beat with AXI_RVALID and AXI_RREADY both 1 SHALL write AXI_RDATA into word slot beat_cnt of Line_Data and increment beat_cnt (log2(NUMBER_WORD) bits, wraps to 0).
REQ-020 Any beat with AXI_RRESP[1]=1 (SLVERR/DECERR) SHALL set a sticky error flag.
REQ-021 A beat with beat_cnt=NUMBER_WORD-1 SHALL move the FSM to DONE; if AXI_RLAST=0 on that beat, the block SHALL set the error flag.
REQ-022 A beat with AXI_RLAST=1 and beat_cnt<NUMBER_WORD-1 SHALL set the error flag and move the FSM to DONE; the remaining slots SHALL keep their old contents.
REQ-023 In DONE, Line_Valid SHALL be 1 and Line_Error SHALL equal the error flag for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-024 Line_Data SHALL hold its value from DONE until the first data beat of the next refill.
REQ-025 Miss_Req SHALL be ignored while Refill_Busy=1; Miss_Req held high in the IDLE cycle after DONE SHALL start a new refill.
REQ-026 Timing: with Miss_Req at edge 0, AXI_ARREADY=1, and RVALID on 8 consecutive cycles, the timeline SHALL be ARVALID in cycle 1, beats in cycles 2-9, and Line_Valid in cycle 10.
REQ-027 A beat that arrives while AXI_RREADY=0 SHALL NOT be consumed.

Reset
REQ-028 When RST=0, the block SHALL asynchronously enter IDLE and clear Line_Data, beat_cnt, error flag, latched address, Line_Valid, Line_Error, Refill_Busy, AXI_ARVALID and AXI_RREADY to 0.
REQ-029 Reset in mid-burst SHALL abandon the burst without a Line_Valid pulse; a new miss after release SHALL start cleanly.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the AXI_ARBURST INCR and AXI_RRESP code constants, and the line-offset-width function.
REQ-031 The block SHALL contain one sub-module, I_Cache_Line_Buffer, which holds the beat counter and word-slot write logic; the FSM and AXI handshakes SHALL stay in I_Cache_Refill.

Verification
REQ-032 Scenario: Miss_ADD=0x0000_1234 with ideal slave (ARREADY=1, RDATA=0x100+beat, RRESP=0, RLAST on beat 7) -> AXI_ARADDR=0x0000_1220, AXI_ARLEN=7; Line_Valid in cycle 10; Line_Data word k=0x100+k; Line_Error=0.
REQ-033 Scenario: AXI_ARREADY held 0 for 5 cycles, and AXI_RVALID toggles 1/0 -> AR outputs stable while stalled; exactly 8 beats captured in order; Line_Valid delayed accordingly.
REQ-034 Scenario: AXI_RRESP=2'b10 on beat 3 only -> all 8 words captured; Line_Valid with Line_Error=1.
REQ-035 Scenario: AXI_RLAST=1 on beat 5 -> DONE after beat 5; Line_Error=1; words 6-7 unchanged.
REQ-036 Scenario: RST=0 asserted after beat 4, then Miss_Req=1 -> outputs 0 with no Line_Valid; the new refill completes normally.
REQ-037 Scenario: Miss_Req pulsed while Refill_Busy=1 -> exactly one AR handshake is issued.
